// File: rtl/mem_access_initiator.sv
// Host-side initiator for the memory-cell control protocol: one request at a time, timeout error.
// Optional build macro RW_CHECK_EN adds a mem_rw versus op consistency check on mem_valid.
module mem_access_initiator #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_sel,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  input  logic              mem_rw
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rw_bad;

`ifdef RW_CHECK_EN
  // Controller reports rw=1 while writing/stable and rw=0 while reading.
  assign rw_bad = (mem_rw != op_q);
`else
  logic unused_mem_rw;
  assign unused_mem_rw = mem_rw;
  assign rw_bad        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mem_valid || (cnt_q == CntMax)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      StIssue: cnt_d = '0;
      StWait: begin
        // A late mem_valid beats the timeout on the final wait cycle.
        if (mem_valid) begin
          err_d   = rw_bad;
          rdata_d = (op_q || rw_bad) ? '0 : mem_rdata;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_sel    = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle:  req_ready  = 1'b1;
      StIssue: mem_sel    = 1'b1;
      StWait:  mem_sel    = 1'b1;
      StDone:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem_op     = op_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: transaction-level model compared every cycle, plus directed
// literal checks; honours RW_CHECK_EN in its expectations.
module tb_mem_access_initiator;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0, req_op = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, resp_valid, resp_err, mem_sel, mem_op;
  logic [7:0] resp_rdata, mem_wdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       mem_valid = 1'b0, mem_rw = 1'b0;

  int n_chk = 0, n_fail = 0;

  mem_access_initiator #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_sel(mem_sel), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_rw(mem_rw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request in flight has an age counted in cycles since acceptance;
  // age 0 is the issue cycle, ages 1..TIMEOUT are wait cycles, then one response cycle.
  logic       m_active, m_done, m_op, m_err, m_rw_bad;
  int         m_age;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, m_rdata;

`ifdef RW_CHECK_EN
  assign m_rw_bad = (mem_rw != m_op);
`else
  assign m_rw_bad = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_op <= 1'b0; m_err <= 1'b0;
      m_age <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active <= 1'b1; m_age <= 0;
        m_op <= req_op; m_addr <= req_addr; m_wdata <= req_wdata;
      end
    end else if (m_age >= 1 && mem_valid) begin
      m_active <= 1'b0; m_done <= 1'b1;
      m_err    <= m_rw_bad;
      m_rdata  <= (m_op || m_rw_bad) ? 8'h00 : mem_rdata;
    end else if (m_age == TIMEOUT) begin
      m_active <= 1'b0; m_done <= 1'b1; m_err <= 1'b1; m_rdata <= 8'h00;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Controller stand-in: random, or mem_valid in a chosen wait cycle (0 = never).
  logic       rand_mode = 1'b0;
  int         tgt = 0;
  logic [7:0] ret_data = '0;
  logic       ret_rw = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_rdata = 8'($urandom);
      mem_rw    = 1'($urandom_range(0, 1));
    end else begin
      mem_valid = m_active && (tgt != 0) && (m_age == tgt);
      mem_rdata = ret_data;
      mem_rw    = ret_rw;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, !m_active && !m_done);
      chk("mem_sel", mem_sel, m_active);
      chk("resp_valid", resp_valid, m_done);
      chk("mem_op", mem_op, m_op);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", resp_err, m_err);
    end
  end

  task automatic run_txn(input logic op, input logic [3:0] addr, input logic [7:0] wd,
                         input int target, input logic [7:0] rd, input logic rw,
                         output int sel_cnt, output int lat, output logic [7:0] got_rd,
                         output logic got_err);
    logic seen;
    @(posedge clk); #1;
    tgt = target; ret_data = rd; ret_rw = rw;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_addr = ~addr; req_wdata = ~wd;
    sel_cnt = 0; lat = 0; seen = 1'b0; got_rd = '0; got_err = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (mem_sel) begin
        sel_cnt++;
        chk("held_addr", mem_addr, addr);
        chk("held_wdata", mem_wdata, wd);
      end
      if (resp_valid) begin
        seen = 1'b1; got_rd = resp_rdata; got_err = resp_err;
      end
    end
    chk("resp_seen", seen, 1'b1);
  endtask

  int         sc, lt, gap;
  logic [7:0] rd;
  logic       er, seen2;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_sel", mem_sel, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    // Write, mem_valid in the first wait cycle: response on the third cycle after accept.
    run_txn(1'b1, 4'h3, 8'hA5, 1, 8'hEE, 1'b1, sc, lt, rd, er);
    chk("wr_sel_cycles", sc, 2);
    chk("wr_latency", lt, 3);
    chk("wr_rdata", rd, 8'h00);
    chk("wr_err", er, 1'b0);

    // Read answered in the fourth wait cycle.
    run_txn(1'b0, 4'hC, 8'h00, 4, 8'h5A, 1'b0, sc, lt, rd, er);
    chk("rd_sel_cycles", sc, 5);
    chk("rd_rdata", rd, 8'h5A);
    chk("rd_err", er, 1'b0);

    // No mem_valid at all: error after TIMEOUT wait cycles.
    run_txn(1'b0, 4'h7, 8'h00, 0, 8'h99, 1'b0, sc, lt, rd, er);
    chk("to_sel_cycles", sc, 1 + TIMEOUT);
    chk("to_rdata", rd, 8'h00);
    chk("to_err", er, 1'b1);

    // mem_valid on the last permitted wait cycle still wins.
    run_txn(1'b0, 4'h1, 8'h00, TIMEOUT, 8'h42, 1'b0, sc, lt, rd, er);
    chk("late_sel_cycles", sc, 1 + TIMEOUT);
    chk("late_rdata", rd, 8'h42);
    chk("late_err", er, 1'b0);

    // Read answered with mem_rw=1.
    run_txn(1'b0, 4'h6, 8'h00, 2, 8'h77, 1'b1, sc, lt, rd, er);
`ifdef RW_CHECK_EN
    chk("rw_rdata", rd, 8'h00);
    chk("rw_err", er, 1'b1);
`else
    chk("rw_rdata", rd, 8'h77);
    chk("rw_err", er, 1'b0);
`endif

    // Back-to-back with req_valid held: deselect in DONE, accept from the following idle cycle.
    @(posedge clk); #1;
    tgt = 1; ret_data = 8'h11; ret_rw = 1'b1;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 4'h5; req_wdata = 8'h3C;
    @(posedge clk); #1;
    req_op = 1'b0; req_addr = 4'h9; req_wdata = 8'h00;
    seen2 = 1'b0;
    for (int i = 0; i < 20 && !seen2; i++) begin
      @(negedge clk);
      if (resp_valid) seen2 = 1'b1;
    end
    chk("b2b_first_resp", seen2, 1'b1);
    ret_rw = 1'b0;
    gap = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_sel) break;
      gap++;
    end
    chk("b2b_gap", gap, 2);
    chk("b2b_second_op", mem_op, 1'b0);
    chk("b2b_second_addr", mem_addr, 4'h9);
    req_valid = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 20 && !seen2; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen2 = 1'b1;
        chk("b2b_rdata", resp_rdata, 8'h11);
      end
    end
    chk("b2b_second_resp", seen2, 1'b1);

    // Reset in the middle of WAIT: immediate deselect, no response afterwards.
    @(posedge clk); #1;
    tgt = 0; req_valid = 1'b1; req_op = 1'b0; req_addr = 4'hB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_sel", mem_sel, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) seen2 = 1'b1;
    end
    chk("midrst_no_resp", seen2, 1'b0);
    chk("midrst_ready_after", req_ready, 1'b1);

    // Random traffic against the model.
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom);
      req_wdata = 8'($urandom);
    end
    req_valid = 1'b0;
    repeat (2 * TIMEOUT) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
